muldiv_sequencer: RTL and testbench

- Multi-cycle sequencer for the RV32M multiply/divide instructions (Funct7 = 0000001).
- Sits beside the single-cycle ALU in EX.
- Accepts one operation per start pulse and iterates a shared shift-add / restoring-subtract datapath one bit per cycle.
- Drives a stall indication to the hazard logic and returns a single-cycle done pulse with the 32-bit result.

---
 rtl/muldiv_sequencer_if.sv | 30 +++
 rtl/muldiv_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_sequencer_if.sv
// Handshake/data bundle between the EX stage and the M-extension sequencer.
//   start  : EX holds a valid M-extension instruction (sampled only when idle)
//   funct3 : instruction bits 14:12 selecting the operation
//   op_a   : rs1 operand, op_b : rs2 operand
//   flush  : kill the in-flight operation
//   busy   : sequencer iterating; hazard unit stalls IF/ID/EX
//   done   : one-cycle pulse, result valid
//   result : product half, quotient or remainder; held until the next done
interface muldiv_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       funct3;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             flush;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;

    modport master (
        output start, funct3, op_a, op_b, flush,
        input  busy, done, result
    );

    modport slave (
        input  start, funct3, op_a, op_b, flush,
        output busy, done, result
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// Multi-cycle RV32M multiply/divide sequencer sitting beside the EX-stage ALU.
// One operation per start pulse; a shared 2*WIDTH accumulator runs either a
// shift-add multiply or a restoring divide, one bit per cycle, followed by a
// one-cycle sign-fix/result-select step and a one-cycle done pulse.
// Ports:
//   clk   : pipeline clock, all state on the rising edge
//   rst_n : asynchronous active-low reset
//   bus   : muldiv_sequencer_if slave (start/funct3/op_a/op_b/flush in,
//           busy/done/result out)
module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    muldiv_sequencer_if.slave   bus
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [2:0]           fn_q;
    logic [2*WIDTH-1:0]   acc_q;      // multiply: {hi, lo}; divide: {rem, quo}
    logic [WIDTH-1:0]     opb_q;      // multiplicand or divisor magnitude
    logic                 neg_q;      // negate the selected result in FIX
    logic [CW-1:0]        cnt_q;
    logic [WIDTH-1:0]     result_q;

    // Two's-complement magnitude when the operand is treated as signed.
    function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v,
                                                   input logic is_signed);
        if (is_signed && v[WIDTH-1])
            return WIDTH'(-v);
        return v;
    endfunction

    function automatic logic [WIDTH-1:0] cond_neg_w(input logic [WIDTH-1:0] v,
                                                    input logic neg);
        return neg ? WIDTH'(-v) : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] cond_neg_2w(input logic [2*WIDTH-1:0] v,
                                                       input logic neg);
        return neg ? (2*WIDTH)'(-v) : v;
    endfunction

    // Start-cycle decode of the incoming operation
    logic             a_signed, b_signed, a_neg, b_neg, neg_d;
    logic             div_zero, div_ovf, fast;
    logic [WIDTH-1:0] fast_res;

    always_comb begin
        a_signed = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b010) ||
                   (bus.funct3 == 3'b100) || (bus.funct3 == 3'b110);
        b_signed = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b100) ||
                   (bus.funct3 == 3'b110);
        a_neg    = a_signed && bus.op_a[WIDTH-1];
        b_neg    = b_signed && bus.op_b[WIDTH-1];
        // Remainder sign follows the dividend; everything else follows a^b.
        if (bus.funct3[2])
            neg_d = bus.funct3[0] ? 1'b0 : (bus.funct3[1] ? a_neg : (a_neg ^ b_neg));
        else
            neg_d = a_neg ^ b_neg;
        div_zero = bus.funct3[2] && (bus.op_b == '0);
        div_ovf  = bus.funct3[2] && !bus.funct3[0] &&
                   (bus.op_a == {1'b1, {(WIDTH-1){1'b0}}}) && (bus.op_b == '1);
        fast     = div_zero || div_ovf;
        if (div_zero)
            fast_res = bus.funct3[1] ? bus.op_a : '1;
        else
            fast_res = bus.funct3[1] ? '0 : bus.op_a;
    end

    // One iteration of each algorithm on the shared accumulator
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next;
    logic [WIDTH:0]       div_diff;
    logic                 div_ge;
    logic [2*WIDTH-1:0]   div_next;

    always_comb begin
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                   (acc_q[0] ? {1'b0, opb_q} : {(WIDTH+1){1'b0}});
        mul_next = {mul_sum, acc_q[WIDTH-1:1]};
        // The shifted remainder is below 2*divisor, so the sign bit of this
        // (WIDTH+1)-bit difference is exactly the restoring compare.
        div_diff = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, opb_q};
        div_ge   = !div_diff[WIDTH];
        div_next = {(div_ge ? div_diff[WIDTH-1:0] : acc_q[2*WIDTH-2:WIDTH-1]),
                    acc_q[WIDTH-2:0], div_ge};
    end

    // Sign correction and result selection
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   fix_res;

    always_comb begin
        prod = cond_neg_2w(acc_q, neg_q);
        unique case (fn_q)
            3'b000:                 fix_res = prod[WIDTH-1:0];
            3'b001, 3'b010, 3'b011: fix_res = prod[2*WIDTH-1:WIDTH];
            3'b100, 3'b101:         fix_res = cond_neg_w(acc_q[WIDTH-1:0], neg_q);
            default:                fix_res = cond_neg_w(acc_q[2*WIDTH-1:WIDTH], neg_q);
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // FSM next state and status outputs
    always_comb begin
        state_d  = state_q;
        bus.busy = 1'b0;
        bus.done = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start && !bus.flush)
                    state_d = fast ? DONE : ITER;
            end
            ITER: begin
                bus.busy = 1'b1;
                if (bus.flush)
                    state_d = IDLE;
                else if (cnt_q == CW'(1))
                    state_d = FIX;
            end
            FIX: begin
                bus.busy = 1'b1;
                state_d  = bus.flush ? IDLE : DONE;
            end
            default: begin
                bus.done = 1'b1;
                state_d  = IDLE;
            end
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fn_q     <= '0;
            acc_q    <= '0;
            opb_q    <= '0;
            neg_q    <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.start && !bus.flush) begin
                        fn_q  <= bus.funct3;
                        acc_q <= {{WIDTH{1'b0}}, magnitude(bus.op_a, a_signed)};
                        opb_q <= magnitude(bus.op_b, b_signed);
                        neg_q <= neg_d;
                        cnt_q <= CW'(WIDTH);
                        if (fast)
                            result_q <= fast_res;
                    end
                end
                ITER: begin
                    acc_q <= fn_q[2] ? div_next : mul_next;
                    cnt_q <= cnt_q - CW'(1);
                end
                FIX: begin
                    // A flushed operation leaves the previous result visible.
                    if (!bus.flush)
                        result_q <= fix_res;
                end
                default: ;
            endcase
        end
    end

    assign bus.result = result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Testbench for muldiv_sequencer: vector table plus hand-written flush and
// reset sequences; expected results are queued at start and checked on done.
module tb_muldiv_sequencer;

    localparam int W = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    muldiv_sequencer_if #(.WIDTH(W)) bus();

    muldiv_sequencer #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    logic [W-1:0] sb[$];

    typedef struct {
        logic [2:0]   f;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp;
        bit           fast;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: every done must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n && bus.done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done with result %h expected no done", bus.result);
            end else begin
                check("result", bus.result, sb.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Called at a negedge; returns at a negedge after the done cycle.
    task automatic run_op(input string name, input logic [2:0] f, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] exp, input bit fast);
        int lat = 0;
        int busy_n = 0;
        bus.start  = 1'b1;
        bus.funct3 = f;
        bus.op_a   = a;
        bus.op_b   = b;
        sb.push_back(exp);
        @(negedge clk);
        bus.start  = 1'b0;
        bus.funct3 = ~f;
        bus.op_a   = ~a;
        bus.op_b   = a ^ b;
        for (int i = 1; i <= 60; i++) begin
            if (bus.done) begin
                lat = i;
                break;
            end
            if (bus.busy)
                busy_n++;
            // A start while busy must be ignored.
            bus.start = (!fast && i == 3);
            @(negedge clk);
        end
        bus.start = 1'b0;
        if (lat == 0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no done expected done within 60 cycles", name);
            if (sb.size() != 0) void'(sb.pop_back());
        end else begin
            check({name, "_latency"}, W'(lat), W'(fast ? 1 : W + 2));
            check({name, "_busy_cycles"}, W'(busy_n), W'(fast ? 0 : W + 1));
            @(negedge clk);
            check({name, "_done_pulse"}, W'(bus.done), '0);
        end
    endtask

    logic [W-1:0] last;

    initial begin
        bus.start  = 1'b0;
        bus.funct3 = '0;
        bus.op_a   = '0;
        bus.op_b   = '0;
        bus.flush  = 1'b0;

        vecs.push_back('{3'b000, 32'd7,         32'd6,         32'h0000002A, 1'b0});
        vecs.push_back('{3'b001, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'h00000000, 1'b0});
        vecs.push_back('{3'b011, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'hFFFFFFFE, 1'b0});
        vecs.push_back('{3'b010, 32'hFFFFFFFF,  32'h00000002,  32'hFFFFFFFF, 1'b0});
        vecs.push_back('{3'b100, 32'hFFFFFFF9,  32'h00000002,  32'hFFFFFFFD, 1'b0});
        vecs.push_back('{3'b110, 32'hFFFFFFF9,  32'h00000002,  32'hFFFFFFFF, 1'b0});
        vecs.push_back('{3'b101, 32'd100,       32'd7,         32'd14,       1'b0});
        vecs.push_back('{3'b111, 32'd100,       32'd7,         32'd2,        1'b0});
        vecs.push_back('{3'b101, 32'd5,         32'd0,         32'hFFFFFFFF, 1'b1});
        vecs.push_back('{3'b110, 32'd5,         32'd0,         32'h00000005, 1'b1});
        vecs.push_back('{3'b100, 32'h80000000,  32'hFFFFFFFF,  32'h80000000, 1'b1});
        vecs.push_back('{3'b110, 32'h80000000,  32'hFFFFFFFF,  32'h00000000, 1'b1});
        vecs.push_back('{3'b000, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'h00000001, 1'b0});
        vecs.push_back('{3'b100, 32'd7,         32'hFFFFFFFE,  32'hFFFFFFFD, 1'b0});
        vecs.push_back('{3'b110, 32'd7,         32'hFFFFFFFE,  32'h00000001, 1'b0});
        vecs.push_back('{3'b110, 32'hFFFFFFF9,  32'hFFFFFFFE,  32'hFFFFFFFF, 1'b0});
        vecs.push_back('{3'b011, 32'h80000000,  32'h00000002,  32'h00000001, 1'b0});
        vecs.push_back('{3'b101, 32'hFFFFFFFF,  32'h00000001,  32'hFFFFFFFF, 1'b0});
        vecs.push_back('{3'b001, 32'h80000000,  32'h80000000,  32'h40000000, 1'b0});
        vecs.push_back('{3'b101, 32'h80000000,  32'hFFFFFFFF,  32'h00000000, 1'b0});
        vecs.push_back('{3'b010, 32'h80000000,  32'hFFFFFFFF,  32'h80000000, 1'b0});
        vecs.push_back('{3'b111, 32'd7,         32'd0,         32'h00000007, 1'b1});

        // Reset state
        repeat (2) @(negedge clk);
        check("reset_busy", W'(bus.busy), '0);
        check("reset_done", W'(bus.done), '0);
        check("reset_result", bus.result, '0);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) begin
            run_op($sformatf("vec%0d", i), vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].fast);
            last = vecs[i].exp;
        end

        // Flush mid-iteration: MUL 3x3 started in cycle 0, flush in cycle 10
        bus.start  = 1'b1;
        bus.funct3 = 3'b000;
        bus.op_a   = 32'd3;
        bus.op_b   = 32'd3;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        check("flush_busy_before", W'(bus.busy), W'(1));
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        check("flush_busy_after", W'(bus.busy), '0);
        check("flush_no_done", W'(bus.done), '0);
        check("flush_result_held", bus.result, last);
        @(negedge clk);
        run_op("divu_after_flush", 3'b101, 32'd9, 32'd3, 32'd3, 1'b0);

        // Flush together with start in IDLE drops the start (fast-path op)
        bus.start  = 1'b1;
        bus.flush  = 1'b1;
        bus.funct3 = 3'b101;
        bus.op_a   = 32'd5;
        bus.op_b   = 32'd0;
        @(negedge clk);
        bus.start = 1'b0;
        bus.flush = 1'b0;
        check("start_flush_no_done", W'(bus.done), '0);
        check("start_flush_no_busy", W'(bus.busy), '0);
        check("start_flush_result", bus.result, 32'd3);
        repeat (3) @(negedge clk);

        // Asynchronous reset in cycle 20 of a DIV
        bus.start  = 1'b1;
        bus.funct3 = 3'b100;
        bus.op_a   = 32'hFFFFFFF9;
        bus.op_b   = 32'd2;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (19) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("rst_mid_busy", W'(bus.busy), '0);
        check("rst_mid_done", W'(bus.done), '0);
        check("rst_mid_result", bus.result, '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op("div_after_reset", 3'b100, 32'd100, 32'hFFFFFFF9, 32'hFFFFFFF2, 1'b0);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", W'(sb.size()), '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
